// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared state encoding, default width and sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

   localparam int C_DEFAULT_WIDTH = 8;

   // 2'd3 is unused and decodes back to IDLE in the FSM default branch
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/Busy/Done handshake and operand/result bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = serial_arith_pkg::C_DEFAULT_WIDTH
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Diff;
   logic             Borrow;

   modport master (output Start, A, B, input Busy, Done, Diff, Borrow);
   modport slave  (input Start, A, B, output Busy, Done, Diff, Borrow);
endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational one-bit full subtractor cell (X - Y - Bin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
   input  wire logic X,
   input  wire logic Y,
   input  wire logic Bin,
   output logic      D,
   output logic      Bout
);
   logic w_xy;

   assign w_xy = X ^ Y;
   assign D    = w_xy ^ Bin;
   assign Bout = (~X & Y) | (~w_xy & Bin);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, LSB first, one borrow flop.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH
) (
   input  wire logic          Clk,
   input  wire logic          Rst,
   serial_subtractor_if.slave bus
);
   localparam int             CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_bor;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_sa_next;

   full_subtractor u_slice (
      .X    (r_sa[0]),
      .Y    (r_sb[0]),
      .Bin  (r_bor),
      .D    (w_d),
      .Bout (w_bout)
   );

   // Difference bits fill the minuend register from the top as its bits are consumed,
   // so after WIDTH shifts r_sa holds the complete result.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sa_next = w_d;
      end else begin : g_wn
         assign w_sa_next = {w_d, r_sa[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= ST_IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_bor    <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.Start) begin
                  r_sa    <= bus.A;
                  r_sb    <= bus.B;
                  r_bor   <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sa  <= w_sa_next;
               r_sb  <= r_sb >> 1;
               r_bor <= w_bout;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  r_diff   <= w_sa_next;
                  r_borrow <= w_bout;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.Busy   = r_busy;
   assign bus.Done   = r_done;
   assign bus.Diff   = r_diff;
   assign bus.Borrow = r_borrow;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor at WIDTH 8 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bor;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [8:0] sb8[$];
   logic [1:0] sb1[$];

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.Clk(clk), .Rst(rst), .bus(bus8));
   serial_subtractor #(.WIDTH(1)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Scoreboards: each Done pulse retires the oldest expected result
   always @(negedge clk) begin
      if (bus8.Done === 1'b1) begin
         if (sb8.size() == 0) check("w8 unexpected done", 1, 0);
         else begin
            logic [8:0] e;
            e = sb8.pop_front();
            check("w8 diff", 32'(bus8.Diff), 32'(e[8:1]));
            check("w8 borrow", 32'(bus8.Borrow), 32'(e[0]));
         end
      end
      if (bus1.Done === 1'b1) begin
         if (sb1.size() == 0) check("w1 unexpected done", 1, 0);
         else begin
            logic [1:0] e;
            e = sb1.pop_front();
            check("w1 diff", 32'(bus1.Diff), 32'(e[1]));
            check("w1 borrow", 32'(bus1.Borrow), 32'(e[0]));
         end
      end
   end

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input string nm);
      int lat;
      int busy;
      @(negedge clk);
      bus8.Start = 1'b1; bus8.A = a; bus8.B = b;
      sb8.push_back({ed, eb});
      @(posedge clk); #1;
      bus8.Start = 1'b0;
      busy = (bus8.Busy === 1'b1) ? 1 : 0;
      lat  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus8.Busy === 1'b1) busy++;
         if (bus8.Done === 1'b1) begin lat = k; break; end
      end
      check({nm, " latency"}, lat, 8);
      check({nm, " busy cycles"}, busy, 8);
      @(posedge clk); #1;
      check({nm, " done pulse"}, 32'(bus8.Done), 0);
   endtask

   task automatic run1(input logic a, input logic b, input logic ed, input logic eb);
      int lat;
      @(negedge clk);
      bus1.Start = 1'b1; bus1.A = a; bus1.B = b;
      sb1.push_back({ed, eb});
      @(posedge clk); #1;
      bus1.Start = 1'b0;
      check("w1 busy after accept", 32'(bus1.Busy), 1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (bus1.Done === 1'b1) begin lat = k; break; end
      end
      check("w1 latency", lat, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs[8];
      int lat;
      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
      vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1};

      bus8.Start = 1'b0; bus8.A = '0; bus8.B = '0;
      bus1.Start = 1'b0; bus1.A = '0; bus1.B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(bus8.Busy), 0);
      check("reset done", 32'(bus8.Done), 0);
      check("reset diff", 32'(bus8.Diff), 0);
      check("reset borrow", 32'(bus8.Borrow), 0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor, $sformatf("vec%0d", i));

      for (int i = 0; i < 16; i++) begin
         logic [7:0] a, b;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         run8(a, b, a - b, (a < b) ? 1'b1 : 1'b0, "rand");
      end

      // Start held through RUN and DONE while operands churn
      @(negedge clk);
      bus8.Start = 1'b1; bus8.A = 8'h05; bus8.B = 8'h03;
      sb8.push_back({8'h02, 1'b0});
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus8.A = 8'($urandom_range(0, 255));
         bus8.B = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
         if (bus8.Done === 1'b1) begin lat = k; break; end
      end
      check("hold latency", lat, 8);
      bus8.A = 8'h10; bus8.B = 8'h01;
      @(posedge clk); #1;
      check("hold no accept in done", 32'(bus8.Busy), 0);
      sb8.push_back({8'h0F, 1'b0});
      @(posedge clk); #1;
      check("hold accept at idle", 32'(bus8.Busy), 1);
      bus8.Start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("diff held in run", 32'(bus8.Diff), 32'h02);
      lat = 0;
      for (int k = 4; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus8.Done === 1'b1) begin lat = k; break; end
      end
      check("back-to-back latency", lat, 8);
      repeat (3) @(posedge clk);
      #1;
      check("diff held in idle", 32'(bus8.Diff), 32'h0F);

      // Reset in the middle of RUN discards the operation
      @(negedge clk);
      bus8.Start = 1'b1; bus8.A = 8'h55; bus8.B = 8'h11;
      @(posedge clk); #1;
      bus8.Start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("midrun rst busy", 32'(bus8.Busy), 0);
      check("midrun rst done", 32'(bus8.Done), 0);
      check("midrun rst diff", 32'(bus8.Diff), 0);
      check("midrun rst borrow", 32'(bus8.Borrow), 0);
      @(negedge clk); bus8.Start = 1'b1;
      @(posedge clk); #1;
      check("rst beats start", 32'(bus8.Busy), 0);
      @(negedge clk); rst = 1'b0; bus8.Start = 1'b0;
      @(posedge clk); #1;
      check("idle after rst+start", 32'(bus8.Busy), 0);
      run8(8'h9A, 8'h2B, 8'h6F, 1'b0, "post reset");

      run1(1'b1, 1'b0, 1'b1, 1'b0);
      run1(1'b0, 1'b1, 1'b1, 1'b1);
      run1(1'b0, 1'b0, 1'b0, 1'b0);
      run1(1'b1, 1'b1, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("w8 scoreboard drained", sb8.size(), 0);
      check("w1 scoreboard drained", sb1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
